// File: rtl/result_collector.sv
// Result collector: captures valid accumulator results from the weight chain, quantises them
// (ReLU, right shift, saturate) and buffers them in a FIFO for a ready/valid consumer.
module result_collector #(
  parameter int DATA_WIDTH    = 32,
  parameter int OUT_WIDTH     = 8,
  parameter int SHIFT         = 0,
  parameter int FIFO_DEPTH    = 8,
  parameter int NEURON_AMOUNT = 4,
  localparam int IDX_W = (NEURON_AMOUNT > 1) ? $clog2(NEURON_AMOUNT) : 1,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   input_result,
  output logic [OUT_WIDTH-1:0]  output_data,
  output logic [IDX_W-1:0]      output_index,
  output logic                  output_last,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_acc;
  logic [DATA_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]  quant;

  assign in_valid = input_result[DATA_WIDTH];
  assign in_acc   = input_result[DATA_WIDTH-1:0];
  assign shifted  = in_acc >> SHIFT;

  generate
    if (OUT_WIDTH < DATA_WIDTH) begin : g_sat
      // Any set bit above the output width means the value exceeds the output range.
      always_comb begin
        quant = shifted[OUT_WIDTH-1:0];
        if (in_acc[DATA_WIDTH-1]) begin
          quant = '0;
        end else if (|shifted[DATA_WIDTH-1:OUT_WIDTH]) begin
          quant = '1;
        end
      end
    end else begin : g_nosat
      always_comb begin
        quant = '0;
        if (!in_acc[DATA_WIDTH-1]) begin
          quant = OUT_WIDTH'(shifted);
        end
      end
    end
  endgenerate

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 overflow_q, overflow_d;
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full = (count_q == CNT_W'(FIFO_DEPTH));
    pop  = (count_q != '0) && output_ready;
    // When full, a simultaneous pop frees the slot the write pointer already addresses.
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    index_d    = index_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = quant;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (index_q == IDX_W'(NEURON_AMOUNT - 1)) begin
        index_d = '0;
      end else begin
        index_d = index_q + IDX_W'(1);
      end
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      index_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      index_q    <= index_d;
      overflow_q <= overflow_d;
    end
  end

  // Entries are cleared on reset so output_data reads 0 while the FIFO is empty after reset.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  assign output_data  = mem_q[rd_ptr_q];
  assign output_index = index_q;
  assign output_last  = (index_q == IDX_W'(NEURON_AMOUNT - 1));
  assign output_valid = (count_q != '0);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule
